sorter_result_streamer: RTL and testbench

Downstream stage of the top-k sorter. Accepts one parallel result frame (the four per-length channel arrays plus channel code) from the sorter top, latches the active channel's sorted elements, and emits the first k of them as a serial valid/ready stream, one element per cycle, rank 1 first. It decouples the sorter's wide parallel output from narrow downstream consumers and applies the runtime top-k cut.

---
 rtl/sorter_pkg.sv | 35 +++
 rtl/sorter_chan_select.sv | 23 ++
 rtl/sorter_result_streamer.sv | 95 +++++++++
 tb/tb_sorter_result_streamer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared types and constants for the top-k sorter and its result streamer.
package sorter_pkg;

    localparam int unsigned DATAWIDTH      = 8;
    localparam int unsigned MAX_DATALENGTH = 32;

    typedef logic [DATAWIDTH-1:0] elem_t;

    // Index 0 of every array is rank 1 (the best element).
    typedef struct packed {
        elem_t [31:0] data_32;
        elem_t [15:0] data_16;
        elem_t [7:0]  data_8;
        elem_t [3:0]  data_4;
    } data_o_t;

    typedef enum logic {IDLE, STREAM} stream_state_e;

    localparam logic [2:0] CH_NONE = 3'd0;
    localparam logic [2:0] CH_4    = 3'd1;
    localparam logic [2:0] CH_8    = 3'd2;
    localparam logic [2:0] CH_16   = 3'd3;
    localparam logic [2:0] CH_32   = 3'd4;

    function automatic logic [5:0] chan_len(input logic [2:0] channel);
        case (channel)
            CH_4:    return 6'd4;
            CH_8:    return 6'd8;
            CH_16:   return 6'd16;
            CH_32:   return 6'd32;
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/sorter_chan_select.sv
// Picks the active channel array out of a result frame as a zero-padded flat list.
module sorter_chan_select
    import sorter_pkg::*;
(
    input  data_o_t                      data,
    input  logic [2:0]                   channel,
    output elem_t [MAX_DATALENGTH-1:0]   elems,
    output logic [5:0]                   len
);

    always_comb begin
        elems = '0;
        len   = chan_len(channel);
        case (channel)
            CH_4:    for (int i = 0; i < 4; i++)  elems[i] = data.data_4[i];
            CH_8:    for (int i = 0; i < 8; i++)  elems[i] = data.data_8[i];
            CH_16:   for (int i = 0; i < 16; i++) elems[i] = data.data_16[i];
            CH_32:   for (int i = 0; i < 32; i++) elems[i] = data.data_32[i];
            default: elems = '0;
        endcase
    end

endmodule

// File: rtl/sorter_result_streamer.sv
// Latches one sorter result frame and streams its first k elements, rank 1 first.
module sorter_result_streamer #(
    parameter int unsigned DATAWIDTH      = sorter_pkg::DATAWIDTH,
    parameter int unsigned MAX_DATALENGTH = sorter_pkg::MAX_DATALENGTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  sorter_pkg::data_o_t   in_data_i,
    input  logic [2:0]            in_channel_i,
    input  logic [5:0]            k_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATAWIDTH-1:0]  out_data_o,
    output logic [4:0]            out_rank_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  err_o
);
    import sorter_pkg::*;

    stream_state_e state_q, state_d;
    logic [4:0]    rank_q, rank_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [MAX_DATALENGTH-1:0][DATAWIDTH-1:0] buf_q, buf_d;

    logic [MAX_DATALENGTH-1:0][DATAWIDTH-1:0] sel_elems;
    logic [5:0] sel_len;
    logic       streaming, is_last, beat, accept;

    sorter_chan_select u_chan_select (
        .data    (in_data_i),
        .channel (in_channel_i),
        .elems   (sel_elems),
        .len     (sel_len)
    );

    assign streaming = (state_q == STREAM);
    assign is_last   = streaming && ({1'b0, rank_q} == cnt_q - 6'd1);
    assign beat      = streaming && out_ready_i;
    // A new frame may slip in on the final beat so consecutive frames have no bubble.
    assign in_ready_o = !streaming || (out_ready_i && is_last);
    assign accept     = in_valid_i && in_ready_o;

    assign out_valid_o = streaming;
    assign out_data_o  = streaming ? buf_q[rank_q] : '0;
    assign out_rank_o  = streaming ? rank_q : '0;
    assign out_last_o  = is_last;
    assign busy_o      = streaming;
    assign err_o       = err_q;

    always_comb begin
        state_d = state_q;
        rank_d  = rank_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        err_d   = 1'b0;
        if (beat) begin
            rank_d = rank_q + 5'd1;
            if (is_last) begin
                state_d = IDLE;
                rank_d  = '0;
            end
        end
        if (accept) begin
            if (sel_len != 6'd0) begin
                buf_d   = sel_elems;
                cnt_d   = (k_i == 6'd0 || k_i > sel_len) ? sel_len : k_i;
                rank_d  = '0;
                state_d = STREAM;
            end else if (in_channel_i > CH_32) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rank_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            rank_q  <= rank_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_sorter_result_streamer.sv
// Randomised bench for sorter_result_streamer against a frame-level reference model.
module tb_sorter_result_streamer;
    import sorter_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    data_o_t     in_data_i = '0;
    logic [2:0]  in_channel_i = 3'd0;
    logic [5:0]  k_i = 6'd0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [7:0]  out_data_o;
    logic [4:0]  out_rank_o;
    logic        out_last_o;
    logic        busy_o;
    logic        err_o;

    int total = 0;
    int bad = 0;

    logic [7:0] got_data[$];
    int         got_rank[$];
    logic       got_last[$];
    int         hold_err;
    int         first_wait;
    bit         timed_out;

    always #5 clk_i = ~clk_i;

    sorter_result_streamer dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .in_channel_i (in_channel_i),
        .k_i          (k_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_rank_o   (out_rank_o),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    // Reference model: the frame's sorted list is its channel array, truncated to k.
    function automatic int ref_len(input int ch);
        return (ch >= 1 && ch <= 4) ? (4 << (ch - 1)) : 0;
    endfunction

    function automatic int ref_cnt(input int ch, input int k);
        int len = ref_len(ch);
        return (k == 0 || k > len) ? len : k;
    endfunction

    function automatic logic [7:0] ref_elem(input data_o_t f, input int ch, input int i);
        case (ch)
            1: return f.data_4[i];
            2: return f.data_8[i];
            3: return f.data_16[i];
            default: return f.data_32[i];
        endcase
    endfunction

    function automatic data_o_t rand_frame();
        data_o_t f;
        for (int i = 0; i < 4; i++)  f.data_4[i]  = 8'($urandom);
        for (int i = 0; i < 8; i++)  f.data_8[i]  = 8'($urandom);
        for (int i = 0; i < 16; i++) f.data_16[i] = 8'($urandom);
        for (int i = 0; i < 32; i++) f.data_32[i] = 8'($urandom);
        return f;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic drive_frame(input data_o_t f, input logic [2:0] ch, input logic [5:0] k);
        bit ok = 0;
        in_valid_i = 1'b1; in_data_i = f; in_channel_i = ch; k_i = k;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk_i);
            ok = in_ready_o;
            @(posedge clk_i); #1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready_o never high, required 1");
        end
        in_valid_i = 1'b0;
        k_i = 6'($urandom);
    endtask

    // mode 0: ready always high, 1: alternate low/high, 2: random.
    task automatic collect(input int mode, input int max_cycles);
        bit pend = 0;
        bit done = 0;
        logic [7:0] pd; logic [4:0] pr; logic pl;
        got_data.delete(); got_rank.delete(); got_last.delete();
        hold_err = 0; first_wait = -1; timed_out = 0;
        for (int c = 0; c < max_cycles; c++) begin
            out_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((c % 2) == 1) :
                          1'($urandom_range(0, 1));
            @(negedge clk_i);
            if (out_valid_o && first_wait < 0) first_wait = c;
            if (pend && (!out_valid_o || out_data_o !== pd || out_rank_o !== pr ||
                         out_last_o !== pl)) hold_err++;
            pend = out_valid_o && !out_ready_i;
            pd = out_data_o; pr = out_rank_o; pl = out_last_o;
            if (out_valid_o && out_ready_i) begin
                got_data.push_back(out_data_o);
                got_rank.push_back(int'(out_rank_o));
                got_last.push_back(out_last_o);
                done = out_last_o;
            end
            @(posedge clk_i); #1;
            if (done) return;
        end
        timed_out = 1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; in_valid_i = 1'b1; in_channel_i = 3'd2; in_data_i = rand_frame();
        out_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            total++; if (out_valid_o !== 1'b0) begin bad++;
                $display("FAIL reset_valid: got %b want 0", out_valid_o); end
            total++; if (in_ready_o !== 1'b1) begin bad++;
                $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
        end
        total++; if (busy_o !== 1'b0 || err_o !== 1'b0 || out_last_o !== 1'b0) begin bad++;
            $display("FAIL reset_flags: busy=%b err=%b last=%b want 0", busy_o, err_o, out_last_o);
        end
        total++; if (out_data_o !== 8'd0 || out_rank_o !== 5'd0) begin bad++;
            $display("FAIL reset_data: data=%0d rank=%0d want 0", out_data_o, out_rank_o); end
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        total++; if (out_valid_o !== 1'b0) begin bad++;
            $display("FAIL post_reset_idle: valid=%b want 0", out_valid_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_topk_directed();
        data_o_t f = rand_frame();
        logic [7:0] exp_d;
        for (int i = 0; i < 8; i++) f.data_8[i] = 8'(90 - 10 * i);
        out_ready_i = 1'b1;
        drive_frame(f, 3'd2, 6'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            exp_d = 8'(90 - 10 * i);
            total++; if (out_valid_o !== 1'b1 || out_data_o !== exp_d) begin bad++;
                $display("FAIL topk_data[%0d]: valid=%b data=%0d want 1/%0d",
                         i, out_valid_o, out_data_o, exp_d); end
            total++; if (out_rank_o !== 5'(i) || out_last_o !== (i == 2)) begin bad++;
                $display("FAIL topk_rank[%0d]: rank=%0d last=%b want %0d/%b",
                         i, out_rank_o, out_last_o, i, i == 2); end
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        total++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++;
            $display("FAIL topk_idle: valid=%b busy=%b want 0/0", out_valid_o, busy_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_full32(input logic [5:0] k);
        data_o_t f = rand_frame();
        drive_frame(f, 3'd4, k);
        collect(1, 200);
        total++; if (timed_out || got_data.size() != 32) begin bad++;
            $display("FAIL full32_count k=%0d: got %0d (timeout=%0d) want 32",
                     k, got_data.size(), timed_out); end
        total++; if (first_wait != 0) begin bad++;
            $display("FAIL full32_latency: first valid after %0d cycles want 0", first_wait); end
        total++; if (hold_err != 0) begin bad++;
            $display("FAIL full32_hold: %0d unstable stalls want 0", hold_err); end
        for (int i = 0; i < got_data.size(); i++) begin
            total++;
            if (got_data[i] !== ref_elem(f, 4, i) || got_rank[i] != i ||
                got_last[i] !== (i == 31)) begin bad++;
                $display("FAIL full32_elem[%0d]: d=%0d r=%0d l=%b want %0d/%0d/%b", i,
                         got_data[i], got_rank[i], got_last[i], ref_elem(f, 4, i), i, i == 31);
            end
        end
    endtask

    task automatic test_back_to_back();
        data_o_t fa = rand_frame();
        data_o_t fb = rand_frame();
        logic [7:0] exp_d;
        out_ready_i = 1'b1;
        in_valid_i = 1'b1; in_data_i = fa; in_channel_i = 3'd1; k_i = 6'd0;
        @(negedge clk_i);
        total++; if (in_ready_o !== 1'b1) begin bad++;
            $display("FAIL b2b_first_ready: got %b want 1", in_ready_o); end
        @(posedge clk_i); #1;
        in_data_i = fb;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            exp_d = (i < 4) ? fa.data_4[i] : fb.data_4[i - 4];
            total++; if (out_valid_o !== 1'b1 || out_data_o !== exp_d ||
                         out_rank_o !== 5'(i % 4) || out_last_o !== ((i % 4) == 3)) begin bad++;
                $display("FAIL b2b_beat[%0d]: v=%b d=%0d r=%0d l=%b want 1/%0d/%0d/%b", i,
                         out_valid_o, out_data_o, out_rank_o, out_last_o, exp_d, i % 4,
                         (i % 4) == 3); end
            if (i < 4) begin
                total++; if (in_ready_o !== (i == 3)) begin bad++;
                    $display("FAIL b2b_in_ready[%0d]: got %b want %b", i, in_ready_o, i == 3);
                end
            end
            @(posedge clk_i); #1;
            if (i == 3) in_valid_i = 1'b0;
        end
        @(negedge clk_i);
        total++; if (out_valid_o !== 1'b0) begin bad++;
            $display("FAIL b2b_end: valid=%b want 0", out_valid_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_bad_channel();
        in_valid_i = 1'b1; in_channel_i = 3'd0; in_data_i = rand_frame(); k_i = 6'd0;
        @(negedge clk_i);
        total++; if (in_ready_o !== 1'b1 || err_o !== 1'b0) begin bad++;
            $display("FAIL ch0_ready: ready=%b err=%b want 1/0", in_ready_o, err_o); end
        @(posedge clk_i); #1;
        in_channel_i = 3'd6;
        @(negedge clk_i);
        total++; if (out_valid_o !== 1'b0 || err_o !== 1'b0 || in_ready_o !== 1'b1) begin
            bad++; $display("FAIL ch0_silent: valid=%b err=%b ready=%b want 0/0/1",
                            out_valid_o, err_o, in_ready_o); end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        total++; if (err_o !== 1'b1 || out_valid_o !== 1'b0) begin bad++;
            $display("FAIL ch6_err: err=%b valid=%b want 1/0", err_o, out_valid_o); end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        total++; if (err_o !== 1'b0 || busy_o !== 1'b0) begin bad++;
            $display("FAIL ch6_pulse: err=%b busy=%b want 0/0", err_o, busy_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_mid();
        data_o_t f = rand_frame();
        data_o_t g = rand_frame();
        logic [5:0] k = 6'($urandom_range(0, 6));
        bit seen = 0;
        out_ready_i = 1'b1;
        drive_frame(f, 3'd3, 6'd0);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk_i);
            seen = out_valid_o && out_rank_o == 5'd5;
            if (!seen) begin @(posedge clk_i); #1; end
        end
        total++; if (!seen || out_data_o !== f.data_16[5]) begin bad++;
            $display("FAIL mid_rank5: seen=%0d data=%0d want 1/%0d", seen, out_data_o,
                     f.data_16[5]); end
        rst_ni = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || out_last_o !== 1'b0 ||
                     out_rank_o !== 5'd0 || out_data_o !== 8'd0) begin bad++;
            $display("FAIL mid_abort: v=%b b=%b l=%b r=%0d d=%0d want all 0", out_valid_o,
                     busy_o, out_last_o, out_rank_o, out_data_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        drive_frame(g, 3'd1, k);
        collect(0, 50);
        total++; if (timed_out || got_data.size() != ref_cnt(1, int'(k))) begin bad++;
            $display("FAIL mid_restart_count: got %0d want %0d", got_data.size(),
                     ref_cnt(1, int'(k))); end
        for (int i = 0; i < got_data.size(); i++) begin
            total++; if (got_data[i] !== g.data_4[i] || got_rank[i] != i) begin bad++;
                $display("FAIL mid_restart[%0d]: d=%0d r=%0d want %0d/%0d", i, got_data[i],
                         got_rank[i], g.data_4[i], i); end
        end
    endtask

    task automatic test_random(input int n);
        for (int t = 0; t < n; t++) begin
            data_o_t f = rand_frame();
            int ch = $urandom_range(1, 4);
            int k = $urandom_range(0, 63);
            int n_exp = ref_cnt(ch, k);
            drive_frame(f, 3'(ch), 6'(k));
            collect(2, 400);
            total++; if (timed_out || got_data.size() != n_exp || hold_err != 0) begin bad++;
                $display("FAIL rand%0d_stream ch=%0d k=%0d: n=%0d hold=%0d to=%0d want %0d/0/0",
                         t, ch, k, got_data.size(), hold_err, timed_out, n_exp); end
            for (int i = 0; i < got_data.size(); i++) begin
                total++;
                if (got_data[i] !== ref_elem(f, ch, i) || got_rank[i] != i ||
                    got_last[i] !== (i == n_exp - 1)) begin bad++;
                    $display("FAIL rand%0d_elem[%0d]: d=%0d r=%0d l=%b want %0d/%0d/%b", t, i,
                             got_data[i], got_rank[i], got_last[i], ref_elem(f, ch, i), i,
                             i == n_exp - 1); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_topk_directed();
        test_full32(6'd0);
        test_full32(6'd40);
        test_back_to_back();
        test_bad_channel();
        test_reset_mid();
        test_random(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
